iserdes_word_aligner: RTL
=========================

Name: iserdes_word_aligner

Overview:
- Sits directly downstream of a 1:4 I_SERDES, in the same fabric clock domain as the SERDES CLK_OUT.
- Trains the lane against a known training nibble by pulsing the SERDES BITSLIP_ADJ input until the pattern is received repeatedly.
- Once locked, packs successive 4-bit SERDES words into wide output words and presents them on a valid/ready interface.

Parameters:
- DATA_WIDTH, 4: SERDES word width. Fixed at 4 for this block.
- TRAIN_PATTERN, 4'h3: training nibble. All 4 rotations must be distinct.
- MATCH_COUNT, 8: consecutive matching valid samples required to lock.
- SLIP_WAIT, 4: clocks to wait after a bitslip pulse before checking again.
- MAX_SLIPS, 8: bitslips allowed before declaring failure.
- OUT_WORDS, 4: nibbles per output word. WORD_OUT width = 4*OUT_WORDS.

Ports:
- CLK  in  1  fabric clock (the SERDES CLK_OUT).
- RST_N  in  1  asynchronous reset, active low.
- PLL_LOCK  in  1  PLL lock; low forces retraining.
- TRAIN_EN  in  1  level; enables training.
- DATA_IN  in  4  SERDES Q.
- DATA_VALID  in  1  SERDES DATA_VALID.
- BITSLIP_ADJ  out  1  one-cycle bitslip pulse to the SERDES.
- ALIGNED  out  1  high in LOCKED.
- ALIGN_ERR  out  1  high in FAIL.
- SLIP_CNT  out  4  bitslips issued in the current training attempt.
- WORD_OUT  out  4*OUT_WORDS  packed word, first nibble in the MSBs.
- WORD_VALID  out  1  WORD_OUT holds a word.
- WORD_READY  in  1  consumer accepts the word.
- OVERFLOW  out  1  sticky; a completed word was dropped.

Behaviour:
- Reset: one clock, CLK; asynchronous active-low reset RST_N. On reset all outputs are 0, the state is IDLE and all counters are 0.
- Sample qualification: a sample is "valid" only when DATA_VALID=1 and PLL_LOCK=1.
- PLL_LOCK=0 in any state: next state is IDLE; WORD_VALID and the partial word are cleared. OVERFLOW is kept.
- IDLE:
  - If TRAIN_EN=1 and PLL_LOCK=1, go to CHECK.
  - On that transition clear match_cnt, SLIP_CNT and OVERFLOW.
- CHECK, on each valid sample:
  - DATA_IN==TRAIN_PATTERN: match_cnt++. If it reaches MATCH_COUNT, go to LOCKED.
  - Mismatch: if SLIP_CNT==MAX_SLIPS, go to FAIL; otherwise go to SLIP.
  - Non-valid cycles: hold state and counters.
- SLIP:
  - BITSLIP_ADJ=1 for exactly this one cycle; SLIP_CNT++.
  - Go to WAIT with wait_cnt=SLIP_WAIT-1.
- WAIT:
  - wait_cnt decrements on every clock, not gated by valid.
  - At 0, go to CHECK with match_cnt=0. Samples arriving during WAIT are ignored.
- LOCKED:
  - ALIGNED=1. Packing is enabled; nib_cnt=0 on entry.
  - The sample that completed training is not packed; the first valid sample after entry is nibble 0.
  - TRAIN_EN is ignored. LOCKED is left only via PLL_LOCK=0 or reset.
- FAIL:
  - ALIGN_ERR=1.
  - TRAIN_EN=0 returns to IDLE. A retry needs TRAIN_EN to go low then high.
- TRAIN_EN=0 in CHECK, SLIP or WAIT: go to IDLE. A BITSLIP_ADJ pulse already being driven in that cycle is still completed.
- Packing:
  - Nibble k of a word goes to WORD_OUT[4*(OUT_WORDS-k)-1 -: 4].
  - The word completes on the valid sample with nib_cnt==OUT_WORDS-1; nib_cnt then wraps to 0.
  - WORD_OUT and WORD_VALID update on the next clock edge (latency 1 after the last nibble).
- Output handshake:
  - A transfer occurs when WORD_VALID and WORD_READY are both 1.
  - WORD_VALID and WORD_OUT are held stable until the transfer.
  - Completion in the same cycle as a transfer: the new word is loaded and WORD_VALID stays 1.
  - Completion while WORD_VALID=1 and WORD_READY=0: the new word is dropped, the old word is kept, and OVERFLOW is set (sticky).
  - Leaving LOCKED clears WORD_VALID.
- Arithmetic:
  - SLIP_CNT saturates at 15.
  - match_cnt and wait_cnt are sized by $clog2 of their parameter+1.

Decomposition:
- Shared package/header iserdes_align_pkg holds:
  - the state encoding: IDLE=0, CHECK=1, SLIP=2, WAIT=3, LOCKED=4, FAIL=5;
  - the default TRAIN_PATTERN;
  - the counter-width helper.
- One sub-module, iserdes_word_packer, holds the nibble shift register, nib_cnt, the valid/ready output register and OVERFLOW. It is enabled by the LOCKED state.
- The alignment FSM stays in the top module.

Test Plan:
- Bench model: a SERDES that rotates its output left by 1 bit per BITSLIP_ADJ pulse.
- Aligned stream: stream of 4'h3, TRAIN_EN=1 -> zero BITSLIP_ADJ pulses; ALIGNED=1 after the 8th valid sample; SLIP_CNT=0.
- Offset 2: stream arrives as 4'hC -> exactly 2 single-cycle BITSLIP_ADJ pulses, each separated by SLIP_WAIT+1 clocks; then ALIGNED=1 and SLIP_CNT=2.
- Failure: constant 4'hF stream -> 8 pulses, then ALIGN_ERR=1 with SLIP_CNT=8. After TRAIN_EN low then high -> SLIP_CNT clears and training restarts.
- Packing and backpressure:
  - After lock, send 1,2,3,4 with WORD_READY=1 -> WORD_OUT=16'h1234 with WORD_VALID for 1 cycle, 1 clock after nibble 4.
  - With WORD_READY=0, send 8 nibbles 5..C -> WORD_OUT stays 16'h5678 and OVERFLOW=1.
- Disruption: drop PLL_LOCK mid-word -> ALIGNED=0 and WORD_VALID=0 next cycle; the partial word is discarded. Assert RST_N=0 mid-SLIP -> BITSLIP_ADJ=0 immediately (asynchronous).

Source files
------------

// File: rtl/iserdes_align_pkg.sv
// Shared definitions for the I_SERDES word aligner: FSM encoding, default
// training nibble and the counter-width helper.
package iserdes_align_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    WAIT   = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_t;

  localparam logic [3:0] TRAIN_PATTERN_DEF = 4'h3;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/iserdes_word_packer.sv
// Packs qualified SERDES nibbles into wide words (first nibble in the MSBs)
// and holds each word on a valid/ready output; a word that cannot be stored sets overflow.
module iserdes_word_packer import iserdes_align_pkg::*; #(
  parameter int DATA_WIDTH = 4,
  parameter int OUT_WORDS  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             smp_vld,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             word_ready,
  input  logic                             ovf_clr,
  output logic [DATA_WIDTH*OUT_WORDS-1:0]  word_out,
  output logic                             word_valid,
  output logic                             overflow
);

  localparam int NW = cnt_w(OUT_WORDS - 1);
  localparam int PW = DATA_WIDTH * (OUT_WORDS - 1);

  logic [NW-1:0] nib_cnt;
  logic [PW-1:0] part;
  logic          last;

  assign last = smp_vld && (nib_cnt == NW'(OUT_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_cnt    <= '0;
      part       <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (ovf_clr) overflow <= 1'b0;
      if (!en) begin
        nib_cnt    <= '0;
        part       <= '0;
        word_valid <= 1'b0;
      end else begin
        if (word_valid && word_ready) word_valid <= 1'b0;
        if (smp_vld) begin
          part <= PW'({part, data_in});
          if (last) begin
            nib_cnt <= '0;
            // a pending word that is not leaving this cycle wins over the new one
            if (!word_valid || word_ready) begin
              word_out   <= {part, data_in};
              word_valid <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else begin
            nib_cnt <= nib_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/iserdes_word_aligner.sv
// Bitslip training FSM for a 1:4 I_SERDES lane; once locked, hands the
// qualified nibble stream to the word packer.
module iserdes_word_aligner import iserdes_align_pkg::*; #(
  parameter int                    DATA_WIDTH    = 4,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEF,
  parameter int                    MATCH_COUNT   = 8,
  parameter int                    SLIP_WAIT     = 4,
  parameter int                    MAX_SLIPS     = 8,
  parameter int                    OUT_WORDS     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pll_lock,
  input  logic                             train_en,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             data_valid,
  output logic                             bitslip_adj,
  output logic                             aligned,
  output logic                             align_err,
  output logic [3:0]                       slip_cnt,
  output logic [DATA_WIDTH*OUT_WORDS-1:0]  word_out,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic                             overflow
);

  localparam int MW = cnt_w(MATCH_COUNT);
  localparam int WW = cnt_w(SLIP_WAIT);

  state_t        state, state_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [3:0]    slip_n;
  logic          smp_vld, ovf_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match_cnt <= '0;
      wait_cnt  <= '0;
      slip_cnt  <= '0;
    end else begin
      state     <= state_n;
      match_cnt <= match_n;
      wait_cnt  <= wait_n;
      slip_cnt  <= slip_n;
    end
  end

  always_comb begin
    smp_vld = data_valid && pll_lock;
    state_n = state;
    match_n = match_cnt;
    wait_n  = wait_cnt;
    slip_n  = slip_cnt;
    ovf_clr = 1'b0;
    case (state)
      IDLE: if (train_en && pll_lock) begin
        state_n = CHECK;
        match_n = '0;
        slip_n  = '0;
        ovf_clr = 1'b1;
      end
      CHECK: if (smp_vld) begin
        if (data_in == TRAIN_PATTERN) begin
          match_n = match_cnt + 1'b1;
          if (match_cnt == MW'(MATCH_COUNT - 1)) state_n = LOCKED;
        end else if (slip_cnt == 4'(MAX_SLIPS)) begin
          state_n = FAIL;
        end else begin
          state_n = SLIP;
        end
      end
      SLIP: begin
        // counted even if training is aborted: the pulse is already on the wire
        if (slip_cnt != 4'hF) slip_n = slip_cnt + 4'd1;
        state_n = WAIT;
        wait_n  = WW'(SLIP_WAIT - 1);
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_n = CHECK;
          match_n = '0;
        end else begin
          wait_n = wait_cnt - 1'b1;
        end
      end
      LOCKED: ;
      FAIL: if (!train_en) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!train_en && (state == CHECK || state == SLIP || state == WAIT)) state_n = IDLE;
    if (!pll_lock) state_n = IDLE;
  end

  assign bitslip_adj = (state == SLIP);
  assign aligned     = (state == LOCKED);
  assign align_err   = (state == FAIL);

  iserdes_word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WORDS  (OUT_WORDS)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         ((state == LOCKED) && pll_lock),
    .smp_vld    (smp_vld),
    .data_in    (data_in),
    .word_ready (word_ready),
    .ovf_clr    (ovf_clr),
    .word_out   (word_out),
    .word_valid (word_valid),
    .overflow   (overflow)
  );

endmodule
